mem_backing_responder: RTL and testbench

Synthesizable responder for the cache-to-memory request interface. It accepts line-beat read and write requests from the cache's memory port, stores data in an internal 128-bit-wide array, and returns read beats in order after a fixed latency. It sits below the cache in simulation and FPGA builds as the main-memory stand-in, and is the reference endpoint for verifying the cache's miss and writeback paths.

---
 rtl/mem_backing_responder_pkg.sv | 29 ++
 rtl/mem_resp_delay_line.sv | 37 +++
 rtl/mem_backing_responder.sv | 119 +++++++++++
 tb/tb_mem_backing_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_backing_responder_pkg.sv
// Shared constants for the memory backing responder: beat width, byte-mask
// width, request address width and the two FSM state encodings.
package mem_backing_responder_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
    localparam int MEM_ADDR_BITS = CPU_ADDR_BITS - 4;

    localparam logic [0:0] MEMB_ACCEPT = 1'b0;
    localparam logic [0:0] MEMB_WDATA  = 1'b1;

    // Overlay the enabled bytes of new_data onto old_data.
    function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
        input logic [MEM_DATA_BITS-1:0] old_data,
        input logic [MEM_DATA_BITS-1:0] new_data,
        input logic [MEM_MASK_BITS-1:0] mask
    );
        logic [MEM_DATA_BITS-1:0] result;
        result = old_data;
        for (int unsigned i = 0; i < MEM_MASK_BITS; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Fixed-latency {valid, data} shift register with synchronous clear.
module mem_resp_delay_line #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned WIDTH   = 128
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   dat_q [LATENCY];

    // Shift one stage per cycle; clear empties every stage.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/mem_backing_responder.sv
// Main-memory stand-in below the cache: byte-masked writes into a 128-bit
// array, in-order read responses after LATENCY cycles.
// Optional build macro: MEM_BACKING_RANDOM_STALL_EN (LFSR-driven request stalls).
module mem_backing_responder
    import mem_backing_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 12,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [0:0]               state_q;
    logic [DEPTH_BITS-1:0]    wr_addr_q;
    logic [MEM_DATA_BITS-1:0] mem [DEPTH];

    logic                     stall;
    logic                     req_fire;
    logic                     rd_fire;
    logic                     wr_en;
    logic                     wr_defer;
    logic [DEPTH_BITS-1:0]    req_addr;
    logic [DEPTH_BITS-1:0]    wr_addr;
    logic [MEM_DATA_BITS-1:0] rd_data;
    logic                     unused_addr_bits;

    assign req_addr         = mem_req_addr[DEPTH_BITS-1:0];
    assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

`ifdef MEM_BACKING_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR (taps 16,14,13,11) advancing every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Handshakes, fire decode and write-first read sampling.
    always_comb begin
        mem_req_ready      = !reset && (state_q == MEMB_ACCEPT) && !stall;
        mem_req_data_ready = (state_q == MEMB_WDATA) ? !reset : mem_req_ready;
        req_fire           = mem_req_valid && mem_req_ready;
        rd_fire            = req_fire && !mem_req_rw;
        wr_defer           = req_fire && mem_req_rw && !mem_req_data_valid;
        wr_en              = (req_fire && mem_req_rw && mem_req_data_valid) ||
                             ((state_q == MEMB_WDATA) && mem_req_data_valid && mem_req_data_ready);
        wr_addr            = (state_q == MEMB_WDATA) ? wr_addr_q : req_addr;
        rd_data            = mem[req_addr];
        if (wr_en && (wr_addr == req_addr)) begin
            rd_data = merge_bytes(rd_data, mem_req_data_bits, mem_req_data_mask);
        end
    end

    // ACCEPT/WDATA state: wait for a deferred write's data beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MEMB_ACCEPT;
        end else if (state_q == MEMB_ACCEPT) begin
            if (wr_defer) begin
                state_q <= MEMB_WDATA;
            end
        end else if (mem_req_data_valid) begin
            state_q <= MEMB_ACCEPT;
        end
    end

    // Latch the address of a write whose data beat has not yet arrived.
    always_ff @(posedge clk) begin
        if (wr_defer) begin
            wr_addr_q <= req_addr;
        end
    end

    // Byte-enabled array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < MEM_MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem[wr_addr][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    mem_resp_delay_line #(
        .LATENCY (LATENCY),
        .WIDTH   (MEM_DATA_BITS)
    ) u_delay (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (rd_fire),
        .in_data   (rd_fire ? rd_data : '0),
        .out_valid (mem_resp_valid),
        .out_data  (mem_resp_data)
    );

endmodule

// File: tb/tb_mem_backing_responder.sv
// Bench for mem_backing_responder (default build, random stall disabled).
module tb_mem_backing_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    mem_backing_responder #(
        .DEPTH_BITS (12),
        .LATENCY    (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        bit           rd;
        logic [27:0]  addr;
        logic [127:0] data;   // write data, or expected read data
        logic [15:0]  mask;
        int           delay;  // cycles between write request and data beat
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           negcount = 0;
    bit           mon_en = 1'b0;
    exp_t         expq[$];
    logic [127:0] model [int];
    vec_t         tbl[16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Response monitor: every cycle either the oldest expected read is due or the bus is idle.
    always @(negedge clk) begin
        negcount++;
        if (mon_en) begin
            if (expq.size() > 0 && expq[0].due == negcount) begin
                chk("resp_valid", {127'b0, mem_resp_valid}, 128'd1);
                chk("resp_data", mem_resp_data, expq[0].data);
                void'(expq.pop_front());
            end else begin
                chk("resp_idle", {127'b0, mem_resp_valid}, 128'd0);
            end
        end
    end

    function automatic void model_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        logic [127:0] cur;
        int k;
        k = int'(a[11:0]);
        cur = model.exists(k) ? model[k] : 128'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
        end
        model[k] = cur;
    endfunction

    function automatic logic [127:0] model_read(input logic [27:0] a);
        int k;
        k = int'(a[11:0]);
        return model.exists(k) ? model[k] : 128'd0;
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic do_idle(input bit stray);
        mem_req_valid      = 1'b0;
        mem_req_data_valid = stray;
        mem_req_data_bits  = {$urandom, $urandom, $urandom, $urandom};
        mem_req_data_mask  = 16'hFFFF;
        @(posedge clk); #1;
        mem_req_data_valid = 1'b0;
    endtask

    task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m, input int dly);
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = a;
        mem_req_data_bits  = d;
        mem_req_data_mask  = m;
        mem_req_data_valid = (dly == 0);
        @(negedge clk); #1;
        chk("wr_req_ready", {127'b0, mem_req_ready}, 128'd1);
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        for (int k = 0; k < dly; k++) begin
            // Scramble address/data to prove the pending write uses latched address and live data.
            mem_req_addr       = 28'($urandom);
            mem_req_data_bits  = {$urandom, $urandom, $urandom, $urandom};
            mem_req_data_valid = 1'b0;
            @(negedge clk); #1;
            chk("wdata_req_ready", {127'b0, mem_req_ready}, 128'd0);
            chk("wdata_data_ready", {127'b0, mem_req_data_ready}, 128'd1);
            @(posedge clk); #1;
        end
        if (dly > 0) begin
            mem_req_data_bits  = d;
            mem_req_data_valid = 1'b1;
            @(posedge clk); #1;
        end
        mem_req_data_valid = 1'b0;
        model_write(a, d, m);
    endtask

    task automatic do_read(input logic [27:0] a, input logic [127:0] exp);
        exp_t e;
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b0;
        mem_req_addr       = a;
        mem_req_data_valid = 1'b0;
        @(negedge clk); #1;
        chk("rd_req_ready", {127'b0, mem_req_ready}, 128'd1);
        e.due  = negcount + LAT;
        e.data = exp;
        expq.push_back(e);
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] d30;
        logic [27:0]  a;

        d1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        d30 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
        tbl[0]  = '{0, 28'h10, d1, 16'hFFFF, 0};
        tbl[1]  = '{1, 28'h10, d1, 16'h0, 0};
        tbl[2]  = '{0, 28'h20, 128'd0, 16'hFFFF, 0};
        tbl[3]  = '{0, 28'h20, {128{1'b1}}, 16'h000F, 0};
        tbl[4]  = '{1, 28'h20, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 16'h0, 0};
        tbl[5]  = '{0, 28'h30, d30, 16'hFFFF, 3};
        tbl[6]  = '{1, 28'h30, d30, 16'h0, 0};
        tbl[7]  = '{0, 28'h0, 128'hA, 16'hFFFF, 0};
        tbl[8]  = '{0, 28'h1, 128'hB, 16'hFFFF, 0};
        tbl[9]  = '{0, 28'h2, 128'hC, 16'hFFFF, 0};
        tbl[10] = '{0, 28'h3, 128'hD, 16'hFFFF, 0};
        tbl[11] = '{1, 28'h0, 128'hA, 16'h0, 0};
        tbl[12] = '{1, 28'h1, 128'hB, 16'h0, 0};
        tbl[13] = '{1, 28'h2, 128'hC, 16'h0, 0};
        tbl[14] = '{1, 28'h3, 128'hD, 16'h0, 0};
        tbl[15] = '{1, 28'hBEEF010, d1, 16'h0, 0};  // upper bits alias onto 0x010

        reset              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req_ready", {127'b0, mem_req_ready}, 128'd0);
        chk("rst_data_ready", {127'b0, mem_req_data_ready}, 128'd0);
        chk("rst_resp_valid", {127'b0, mem_resp_valid}, 128'd0);
        chk("rst_resp_data", mem_resp_data, 128'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("release_req_ready", {127'b0, mem_req_ready}, 128'd1);
        chk("release_data_ready", {127'b0, mem_req_data_ready}, 128'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;
        repeat (10) do_idle(1'b0);

        // Table-driven directed vectors, issued back to back
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rd) do_read(tbl[i].addr, tbl[i].data);
            else           do_write(tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].delay);
        end
        repeat (LAT + 2) do_idle(1'b0);

        // Stray data beat in ACCEPT is ignored
        do_idle(1'b1);
        do_idle(1'b1);
        do_read(28'h10, d1);
        repeat (LAT + 2) do_idle(1'b0);

        // Reset two cycles after a read fires: the response is discarded
        do_read(28'h10, d1);
        do_idle(1'b0);
        reset = 1'b1;
        expq.delete();
        @(negedge clk); #1;
        chk("midrst_req_ready", {127'b0, mem_req_ready}, 128'd0);
        chk("midrst_data_ready", {127'b0, mem_req_data_ready}, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) do_idle(1'b0);

        // Reset while a write's data beat is pending returns to ACCEPT
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 28'h50;
        mem_req_data_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("wdata_rst_ready", {127'b0, mem_req_ready}, 128'd1);
        @(posedge clk); #1;

        // Randomised traffic against the reference model
        for (int i = 0; i < 16; i++) begin
            a = 28'($urandom);
            a[11:0] = 12'h040 + 12'(i);
            do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0);
        end
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            a = 28'($urandom);
            a[11:0] = 12'h040 + 12'($urandom_range(0, 15));
            if (r < 4)      do_read(a, model_read(a));
            else if (r < 7) do_write(a, {$urandom, $urandom, $urandom, $urandom},
                                     16'($urandom), int'($urandom_range(0, 2)));
            else            do_idle(r == 9);
        end

        // Drain with a bounded wait
        for (int n = 0; n < 20 && expq.size() > 0; n++) do_idle(1'b0);
        chk("drain_empty", 128'(expq.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
